// File: rtl/module_status_receiver.sv
// module_status_receiver: 8N1 UART frame receiver with a per-module
// status register bank and a millisecond watchdog per slot.
//
// Ports:
//   CLOCK_50      system clock, rising edge
//   RESET_N       async active-low reset
//   UART_RXD      serial input, idle high, asynchronous
//   MODULE_STATUS slot i at [4*i+3:4*i]
//   MODULE_VALID  bit i set while slot i holds a fresh report
//   FRAME_OK      1-cycle pulse on an accepted frame
//   FRAME_ERR     1-cycle pulse on framing/ID/nibble/checksum error
//
// Frame format: A5, ID, STAT, A5^ID^STAT.

module module_status_receiver #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned NUM_MODULES  = 4,
  parameter int unsigned TIMEOUT_MS   = 2000,
  parameter logic [3:0]  OFFLINE_CODE = 4'hF
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  input  logic                     UART_RXD,
  output logic [4*NUM_MODULES-1:0] MODULE_STATUS,
  output logic [NUM_MODULES-1:0]   MODULE_VALID,
  output logic                     FRAME_OK,
  output logic                     FRAME_ERR
);

  localparam int unsigned CPB     = CLK_HZ / BAUD;
  localparam int unsigned HALF    = CPB / 2;
  localparam int unsigned MS_CLKS = CLK_HZ / 1000;
  localparam int          CW      = $clog2(CPB + 1);
  localparam int          PW      = $clog2(MS_CLKS + 1);

  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [PW-1:0] MS_M1   = PW'(MS_CLKS - 1);
  localparam logic [15:0]   TMO     = 16'(TIMEOUT_MS);
  localparam logic [15:0]   TMO_M1  = 16'(TIMEOUT_MS - 1);
  localparam logic [7:0]    HDR     = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    HUNT, GOT_HDR, GOT_ID, GOT_STAT
  } p_state_t;

  // ---------------- input synchronizer ----------------
  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RXD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A start needs a high-to-low edge, so after a framing
  // error the FSM naturally waits for the line to go high.
  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------- UART FSM ----------------
  rx_state_t        rx_state, rx_next;
  logic [CW-1:0]    rx_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             cnt_done;
  logic             byte_valid;
  logic             frame_bad;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  always_comb begin
    cnt_done = 1'b0;
    unique case (rx_state)
      RX_START:         cnt_done = (rx_cnt == HALF_M1);
      RX_DATA, RX_STOP: cnt_done = (rx_cnt == CPB_M1);
      default:          cnt_done = 1'b0;
    endcase
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (cnt_done)
                  rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_done && bit_idx == 3'd7)
                  rx_next = RX_STOP;
      RX_STOP:  if (cnt_done) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_bad  = 1'b0;
    if (rx_state == RX_STOP && cnt_done) begin
      byte_valid = rx_sync;
      frame_bad  = ~rx_sync;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || cnt_done) rx_cnt <= '0;
      else                                 rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) begin
        bit_idx <= '0;
      end else if (rx_state == RX_DATA && cnt_done) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 1'b1;
      end
    end
  end

  // ---------------- frame parser ----------------
  p_state_t   p_state, p_next;
  logic [7:0] id_q, stat_q;
  logic       id_bad, stat_bad, sum_ok;
  logic       p_accept, p_err;

  assign id_bad   = (rx_shift >= 8'(NUM_MODULES));
  assign stat_bad = |rx_shift[7:4];
  assign sum_ok   = (rx_shift == (HDR ^ id_q ^ stat_q));

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) p_state <= HUNT;
    else          p_state <= p_next;
  end

  always_comb begin
    p_next = p_state;
    if (frame_bad) begin
      p_next = HUNT;
    end else if (byte_valid) begin
      unique case (p_state)
        HUNT:     if (rx_shift == HDR) p_next = GOT_HDR;
        GOT_HDR:  p_next = id_bad ? HUNT : GOT_ID;
        GOT_ID:   p_next = stat_bad ? HUNT : GOT_STAT;
        GOT_STAT: p_next = HUNT;
        default:  p_next = HUNT;
      endcase
    end
  end

  always_comb begin
    p_accept = 1'b0;
    p_err    = 1'b0;
    if (byte_valid) begin
      unique case (p_state)
        GOT_HDR:  p_err = id_bad;
        GOT_ID:   p_err = stat_bad;
        GOT_STAT: begin
          p_accept = sum_ok;
          p_err    = ~sum_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      id_q   <= '0;
      stat_q <= '0;
    end else if (byte_valid) begin
      if (p_state == GOT_HDR) id_q   <= rx_shift;
      if (p_state == GOT_ID)  stat_q <= rx_shift;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_OK  <= p_accept;
      FRAME_ERR <= p_err | frame_bad;
    end
  end

  // ---------------- ms prescaler ----------------
  logic [PW-1:0] pre_cnt;
  logic          ms_tick;

  assign ms_tick = (pre_cnt == MS_M1);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)     pre_cnt <= '0;
    else if (ms_tick) pre_cnt <= '0;
    else              pre_cnt <= pre_cnt + 1'b1;
  end

  // ---------------- status slots ----------------
  for (genvar i = 0; i < NUM_MODULES; i++) begin : g_slot
    logic        hit;
    logic [15:0] ms_cnt;
    logic [3:0]  stat_r;
    logic        val_r;

    assign hit = p_accept && (id_q == 8'(i));

    // Accept has priority over a same-cycle timeout.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        ms_cnt <= '0;
        stat_r <= OFFLINE_CODE;
        val_r  <= 1'b0;
      end else if (hit) begin
        ms_cnt <= '0;
        stat_r <= stat_q[3:0];
        val_r  <= 1'b1;
      end else if (ms_tick && ms_cnt != TMO) begin
        ms_cnt <= ms_cnt + 1'b1;
        if (ms_cnt == TMO_M1) begin
          stat_r <= OFFLINE_CODE;
          val_r  <= 1'b0;
        end
      end
    end

    assign MODULE_STATUS[4*i +: 4] = stat_r;
    assign MODULE_VALID[i]         = val_r;
  end

endmodule
